maze_window_tracker: RTL and testbench

//   Streaming maze front end: binarizes 8-bit video, builds a WIN x WIN binary sliding

---
 rtl/maze_window_tracker.sv | 263 ++++++++++++++++++++++++++
 tb/tb_maze_window_tracker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_window_tracker.sv
// Streaming maze front end: binarize video, slide a WIN x WIN bit window, lock the maze
// entrance on SCAN_ROW and overlay a marker. Define MAZE_TRACK_PATHW_EN for the path_width port.
module maze_window_tracker #(
  parameter int THRESH   = 200,
  parameter int WIN      = 33,
  parameter int LINE_W   = 1024,
  parameter int SCAN_ROW = 16,
  parameter int MARK_R   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       video_frame_valid,
  input  logic       video_line_valid,
  input  logic       video_data_valid,
  input  logic [7:0] video_data_in,
  output logic       video_data_ready,
  output logic [7:0] video_data_out,
  output logic       start_valid,
  output logic [9:0] start_x,
  output logic [9:0] start_y
`ifdef MAZE_TRACK_PATHW_EN
  ,
  output logic [9:0] path_width
`endif
);
  localparam int C  = WIN / 2;
  localparam int CW = 10;
  localparam int BW = WIN - 1;
  localparam logic [CW-1:0]        H_MAX  = CW'(LINE_W - 1);
  localparam logic [CW-1:0]        SCAN_V = CW'(SCAN_ROW);
  localparam logic signed [CW:0]   MR     = 11'(MARK_R);

  logic           fv_prev_q, fv_prev_d, lv_prev_q, lv_prev_d, active_q, active_d;
  logic [CW-1:0]  cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic           full_q, full_d, prev_bin_q, prev_bin_d;
  logic [CW-1:0]  left_q, left_d, right_q, right_d;
  logic           left_seen_q, left_seen_d, right_seen_q, right_seen_d;
  logic           start_valid_q, start_valid_d;
  logic [CW-1:0]  start_x_q, start_x_d, start_y_q, start_y_d;
  logic           ready_q, ready_d;
  logic [7:0]     out_q, out_d;
  logic [WIN-1:0] win_q [WIN];
  logic [WIN-1:0] win_d [WIN];

  logic           fv_rise, fv_fall, lv_fall, active, pix, bin, scan;
  logic           lock_ok, pw_ok, in_mark;
  logic [CW:0]    mid_sum;
  logic signed [CW:0] dx, dy;
  logic [WIN-1:0] col;

  // Line buffers: one word per column, bit r-1 holds the pixel from r lines above.
  logic [BW-1:0]  lb_mem [LINE_W];
  logic [BW-1:0]  mem_rd_q, byp_data_q, lb_word, wr_data;
  logic           byp_q, wr_en;
  logic [CW-1:0]  rd_addr;

  always_comb begin
    fv_rise = video_frame_valid & ~fv_prev_q;
    active  = active_q | fv_rise;
    fv_fall = ~video_frame_valid & fv_prev_q & active_q;
    lv_fall = ~video_line_valid & lv_prev_q & active_q;
    pix     = video_data_valid & active;
    bin     = video_data_in > 8'(THRESH);
    scan    = pix & (cnt_v_q == SCAN_V) & ~start_valid_q;
  end

  // The next column's word is prefetched so the pixel strobe sees it with no extra latency.
  assign rd_addr = cnt_h_d;
  assign wr_en   = pix & ~full_q;
  assign wr_data = col[BW-1:0];
  assign lb_word = byp_q ? byp_data_q : mem_rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb_mem[cnt_h_q] <= wr_data;
    end
    mem_rd_q   <= lb_mem[rd_addr];
    byp_data_q <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= wr_en & (cnt_h_q == rd_addr);
    end
  end

  // Rows older than the current field read as 0, which also flushes stale buffer data.
  assign col[0] = bin;
  generate
    for (genvar gi = 1; gi < WIN; gi++) begin : g_col
      assign col[gi] = (cnt_v_q >= CW'(gi)) & lb_word[gi-1];
    end
    for (genvar gi = 0; gi < WIN; gi++) begin : g_win
      assign win_d[gi] = pix ? {win_q[gi][WIN-2:0], col[gi]} : win_q[gi];
    end
  endgenerate

  always_comb begin
    fv_prev_d     = video_frame_valid;
    lv_prev_d     = video_line_valid;
    active_d      = active;
    cnt_h_d       = cnt_h_q;
    cnt_v_d       = cnt_v_q;
    full_d        = full_q;
    prev_bin_d    = prev_bin_q;
    left_d        = left_q;
    right_d       = right_q;
    left_seen_d   = left_seen_q;
    right_seen_d  = right_seen_q;
    start_valid_d = start_valid_q;
    start_x_d     = start_x_q;
    start_y_d     = start_y_q;
    ready_d       = pix;
    out_d         = out_q;
    mid_sum       = {1'b0, left_q} + {1'b0, right_q};
    dx            = $signed({1'b0, cnt_h_q}) - $signed({1'b0, start_x_q});
    dy            = $signed({1'b0, cnt_v_q}) - $signed({1'b0, start_y_q});
    in_mark       = start_valid_q && (dx <= MR) && (dx >= -MR) && (dy <= MR) && (dy >= -MR);
    lock_ok       = left_seen_q & right_seen_q & (right_q > left_q) & pw_ok;

    if (pix) begin
      prev_bin_d = bin;
      if (!full_q) begin
        if (cnt_h_q == H_MAX) begin
          full_d = 1'b1;
        end else begin
          cnt_h_d = cnt_h_q + CW'(1);
        end
      end
      if (scan && !prev_bin_q && bin && !left_seen_q) begin
        left_d      = cnt_h_q;
        left_seen_d = 1'b1;
      end
      // Right edge is the last white column, one before the falling transition.
      if (scan && prev_bin_q && !bin) begin
        right_d      = cnt_h_q - CW'(1);
        right_seen_d = 1'b1;
      end
      case (mode)
        2'd0:    out_d = video_data_in;
        2'd1:    out_d = {8{bin}};
        2'd2:    out_d = {8{win_d[C][C]}};
        default: out_d = in_mark ? 8'd255 : {1'b0, {7{bin}}};
      endcase
    end

    if (lv_fall) begin
      cnt_h_d    = '0;
      full_d     = 1'b0;
      prev_bin_d = 1'b0;
      cnt_v_d    = cnt_v_q + CW'(1);
    end

    if (fv_fall) begin
      cnt_h_d      = '0;
      cnt_v_d      = '0;
      full_d       = 1'b0;
      prev_bin_d   = 1'b0;
      left_seen_d  = 1'b0;
      right_seen_d = 1'b0;
      if (!start_valid_q && lock_ok) begin
        start_valid_d = 1'b1;
        start_x_d     = mid_sum[CW:1];
        start_y_d     = SCAN_V - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fv_prev_q     <= 1'b1;
      lv_prev_q     <= 1'b0;
      active_q      <= 1'b0;
      cnt_h_q       <= '0;
      cnt_v_q       <= '0;
      full_q        <= 1'b0;
      prev_bin_q    <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      left_seen_q   <= 1'b0;
      right_seen_q  <= 1'b0;
      start_valid_q <= 1'b0;
      start_x_q     <= '0;
      start_y_q     <= '0;
      ready_q       <= 1'b0;
      out_q         <= '0;
      for (int r = 0; r < WIN; r++) begin
        win_q[r] <= '0;
      end
    end else begin
      fv_prev_q     <= fv_prev_d;
      lv_prev_q     <= lv_prev_d;
      active_q      <= active_d;
      cnt_h_q       <= cnt_h_d;
      cnt_v_q       <= cnt_v_d;
      full_q        <= full_d;
      prev_bin_q    <= prev_bin_d;
      left_q        <= left_d;
      right_q       <= right_d;
      left_seen_q   <= left_seen_d;
      right_seen_q  <= right_seen_d;
      start_valid_q <= start_valid_d;
      start_x_q     <= start_x_d;
      start_y_q     <= start_y_d;
      ready_q       <= ready_d;
      out_q         <= out_d;
      for (int r = 0; r < WIN; r++) begin
        win_q[r] <= win_d[r];
      end
    end
  end

`ifdef MAZE_TRACK_PATHW_EN
  logic [CW-1:0] pw_cnt_q, pw_cnt_d, path_width_q, path_width_d;

  always_comb begin
    pw_cnt_d     = pw_cnt_q;
    path_width_d = path_width_q;
    if (scan && bin && (pw_cnt_q != '1)) begin
      pw_cnt_d = pw_cnt_q + CW'(1);
    end
    if (fv_fall) begin
      pw_cnt_d = '0;
      if (!start_valid_q && lock_ok) begin
        path_width_d = pw_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pw_cnt_q     <= '0;
      path_width_q <= '0;
    end else begin
      pw_cnt_q     <= pw_cnt_d;
      path_width_q <= path_width_d;
    end
  end

  assign pw_ok      = pw_cnt_q >= CW'(3);
  assign path_width = path_width_q;
`else
  assign pw_ok = 1'b1;
`endif

  // Only the centre tap drives the output; the rest of the window is kept for reuse.
  logic unused_bits;
  always_comb begin
    unused_bits = mid_sum[0];
    for (int r = 0; r < WIN; r++) begin
      unused_bits = unused_bits ^ (^win_q[r]);
    end
  end

  assign video_data_ready = ready_q;
  assign video_data_out   = out_q;
  assign start_valid      = start_valid_q;
  assign start_x          = start_x_q;
  assign start_y          = start_y_q;
endmodule

// File: tb/tb_maze_window_tracker.sv
// Directed bench for maze_window_tracker: expected pixels are queued when driven and
// compared when video_data_ready fires; lock results are checked against fixed constants.
module tb_maze_window_tracker;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       video_frame_valid, video_line_valid, video_data_valid;
  logic [7:0] video_data_in;
  logic       video_data_ready;
  logic [7:0] video_data_out;
  logic       start_valid;
  logic [9:0] start_x, start_y;
`ifdef MAZE_TRACK_PATHW_EN
  logic [9:0] path_width;
`endif

  always #5 clk = ~clk;

  maze_window_tracker dut (
    .clk               (clk),
    .reset             (reset),
    .mode              (mode),
    .video_frame_valid (video_frame_valid),
    .video_line_valid  (video_line_valid),
    .video_data_valid  (video_data_valid),
    .video_data_in     (video_data_in),
    .video_data_ready  (video_data_ready),
    .video_data_out    (video_data_out),
    .start_valid       (start_valid),
    .start_x           (start_x),
    .start_y           (start_y)
`ifdef MAZE_TRACK_PATHW_EN
    ,
    .path_width        (path_width)
`endif
  );

  typedef struct {
    logic [7:0] val;
    int         x;
    int         y;
    logic [1:0] m;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic img_bin [64][1024];
  int   line_w = 128;
  logic exp_locked = 1'b0;
  localparam int EXP_SX = 319;
  localparam int EXP_SY = 15;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int sel, input int y, input int x);
    case (sel)
      1: gen = (y == 40 && x == 100) ? 8'd230 : 8'((x * 7 + y * 3) % 200);
      2: begin
        if (y == 16) gen = (x >= 300 && x <= 339) ? 8'd255 : 8'((x + y) % 150);
        else         gen = ((x % 64) < 10) ? 8'd250 : 8'd20;
      end
      default: gen = (((x ^ y) & 8) != 0) ? 8'd210 : 8'd100;
    endcase
  endfunction

  function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] d,
                                       input int x, input int y);
    logic b, c, inm;
    int   ry, rx;
    b = d > 8'd200;
    case (m)
      2'd0: return d;
      2'd1: return b ? 8'hFF : 8'h00;
      2'd2: begin
        // Centre lags 16 rows / 16 columns; early columns reach back into the previous line.
        if (x >= 16) begin ry = y - 16; rx = x - 16; end
        else begin ry = y - 17; rx = line_w + x - 16; end
        c = (ry >= 0 && ry < 64 && rx >= 0 && rx < 1024) ? img_bin[ry][rx] : 1'b0;
        return c ? 8'hFF : 8'h00;
      end
      default: begin
        inm = exp_locked && (x - EXP_SX <= 4) && (EXP_SX - x <= 4) &&
              (y - EXP_SY <= 4) && (EXP_SY - y <= 4);
        return inm ? 8'hFF : (b ? 8'h7F : 8'h00);
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (video_data_ready === 1'b1) begin
      check("out_has_expect", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check($sformatf("pix m%0d y%0d x%0d", mon_e.m, mon_e.y, mon_e.x),
              32'(video_data_out), 32'(mon_e.val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [7:0] d, input int x, input int y);
    exp_t e;
    video_data_valid = 1'b1;
    video_data_in    = d;
    e.val = model(mode, d, x, y);
    e.x   = x;
    e.y   = y;
    e.m   = mode;
    exp_q.push_back(e);
    if (y < 64 && x < 1024) img_bin[y][x] = (d > 8'd200);
    tick();
    video_data_valid = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int w, input int sel);
    int wl;
    line_w = w;
    video_frame_valid = 1'b1;
    tick();
    for (int y = 0; y < lines; y++) begin
      // Two extra pixels on the first line of the wide frame exercise column saturation.
      wl = (sel == 2 && y == 0) ? w + 2 : w;
      video_line_valid = 1'b1;
      tick();
      for (int x = 0; x < wl; x++) send_px(gen(sel, y, x), x, y);
      tick();
      video_line_valid = 1'b0;
      tick();
      tick();
    end
    video_frame_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    mode = 2'd0;
    video_frame_valid = 1'b0;
    video_line_valid = 1'b0;
    video_data_valid = 1'b0;
    video_data_in = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(video_data_ready), 32'd0);
    check("rst_out", 32'(video_data_out), 32'd0);
    check("rst_start_valid", 32'(start_valid), 32'd0);
    check("rst_start_x", 32'(start_x), 32'd0);
    check("rst_start_y", 32'(start_y), 32'd0);

    // Test 1: pass-through pixels, then reset mid-line while a pixel is strobed.
    video_frame_valid = 1'b1;
    tick();
    video_line_valid = 1'b1;
    tick();
    send_px(8'd10, 0, 0);
    send_px(8'd20, 1, 0);
    send_px(8'd250, 2, 0);
    send_px(8'd77, 3, 0);
    send_px(8'd201, 4, 0);
    reset = 1'b1;
    video_data_valid = 1'b1;
    video_data_in = 8'd99;
    tick();
    check("midrst_ready", 32'(video_data_ready), 32'd0);
    check("midrst_out", 32'(video_data_out), 32'd0);
    check("midrst_start_valid", 32'(start_valid), 32'd0);
    video_data_valid = 1'b0;
    video_line_valid = 1'b0;
    video_frame_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("idle_ready", 32'(video_data_ready), 32'd0);
    check("idle_out", 32'(video_data_out), 32'd0);
    drain("drain_t1");

    // Test 3: threshold boundary in mode 1, mode changes between pixels, output hold.
    video_frame_valid = 1'b1;
    tick();
    video_line_valid = 1'b1;
    tick();
    mode = 2'd1;
    send_px(8'd200, 0, 0);
    send_px(8'd201, 1, 0);
    send_px(8'd0, 2, 0);
    send_px(8'd255, 3, 0);
    mode = 2'd0;
    send_px(8'd150, 4, 0);
    mode = 2'd3;
    send_px(8'd210, 5, 0);
    tick();
    tick();
    check("hold_ready", 32'(video_data_ready), 32'd0);
    check("hold_out", 32'(video_data_out), 32'd127);
    video_line_valid = 1'b0;
    tick();
    video_frame_valid = 1'b0;
    tick();
    tick();
    drain("drain_t3");

    // Test 4 / 6a: window centre in mode 2; black scan row must not lock.
    mode = 2'd2;
    send_frame(60, 128, 1);
    drain("drain_t4");
    check("nolock_start_valid", 32'(start_valid), 32'd0);

    // Test 2 / 6b: 1024-pixel frame with an opening at 300..339 locks.
    mode = 2'd1;
    send_frame(17, 1024, 2);
    drain("drain_t2");
    check("lock_start_valid", 32'(start_valid), 32'd1);
    check("lock_start_x", 32'(start_x), 32'(EXP_SX));
    check("lock_start_y", 32'(start_y), 32'(EXP_SY));
`ifdef MAZE_TRACK_PATHW_EN
    check("lock_path_width", 32'(path_width), 32'd40);
`endif
    exp_locked = 1'b1;

    // Test 5: marker overlay in mode 3; lock values hold afterwards.
    mode = 2'd3;
    send_frame(24, 340, 3);
    drain("drain_t5");
    check("hold_start_valid", 32'(start_valid), 32'd1);
    check("hold_start_x", 32'(start_x), 32'(EXP_SX));
    check("hold_start_y", 32'(start_y), 32'(EXP_SY));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
